// File: rtl/dequant_pkg.sv
// Shared widths, FSM state type and S1 payload for the dequant_stream datapath.
package dequant_pkg;

    localparam int DQ_IN_WIDTH    = 8;
    localparam int DQ_SCALE_WIDTH = 12;
    localparam int DQ_SHIFT_WIDTH = 4;
    localparam int DQ_OUT_WIDTH   = 21;
    localparam int DQ_VEC_LEN     = 64;
    localparam int DQ_PROD_WIDTH  = DQ_IN_WIDTH + DQ_SCALE_WIDTH;

    // Element counter width; a one-element vector still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DQ_CNT_WIDTH = cnt_width(DQ_VEC_LEN);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic signed [DQ_PROD_WIDTH-1:0]  prod;
        logic        [DQ_SHIFT_WIDTH-1:0] shift;
        logic                             last;
    } s1_payload_t;

endpackage

// File: rtl/dequant_shift_round.sv
// Combinational S2 datapath: sign-extend the product and arithmetic-shift it right.
// DEQUANT_ROUND_EN selects round-half-up; otherwise the shift floors toward -inf.
module dequant_shift_round
    import dequant_pkg::*;
#(
    parameter int PROD_WIDTH  = DQ_PROD_WIDTH,
    parameter int SHIFT_WIDTH = DQ_SHIFT_WIDTH,
    parameter int OUT_WIDTH   = DQ_OUT_WIDTH
) (
    input  logic signed [PROD_WIDTH-1:0]  prod,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    output logic signed [OUT_WIDTH-1:0]   result
);

`ifdef DEQUANT_ROUND_EN
    localparam logic signed [OUT_WIDTH-1:0] ONE_C = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
`endif

    logic signed [OUT_WIDTH-1:0] ext_s;
    logic signed [OUT_WIDTH-1:0] rnd_s;
    logic signed [OUT_WIDTH-1:0] sum_s;

    // Widen, add the optional half-LSB bias, then shift; the sum cannot overflow OUT_WIDTH.
    always_comb begin
        ext_s = {{(OUT_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
        rnd_s = {OUT_WIDTH{1'b0}};
`ifdef DEQUANT_ROUND_EN
        if (shift != {SHIFT_WIDTH{1'b0}}) begin
            rnd_s = ONE_C << (shift - SHIFT_WIDTH'(1));
        end else begin
            rnd_s = {OUT_WIDTH{1'b0}};
        end
`endif
        sum_s  = ext_s + rnd_s;
        result = sum_s >>> shift;
    end

endmodule

// File: rtl/dequant_stream.sv
// Streaming int8 dequantizer: out = (in_data * scale) >>> shift at accumulator width.
// Optional round-half-up via DEQUANT_ROUND_EN (see dequant_shift_round).
module dequant_stream
    import dequant_pkg::*;
#(
    parameter int IN_WIDTH    = DQ_IN_WIDTH,
    parameter int OUT_WIDTH   = DQ_OUT_WIDTH,
    parameter int SCALE_WIDTH = DQ_SCALE_WIDTH,
    parameter int SHIFT_WIDTH = DQ_SHIFT_WIDTH,
    parameter int VEC_LEN     = DQ_VEC_LEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [SCALE_WIDTH-1:0] cfg_scale,
    input  logic [SHIFT_WIDTH-1:0] cfg_shift,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_WIDTH-1:0]    in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_WIDTH-1:0]   out_data,
    output logic                   out_last
);

    localparam int PROD_W = IN_WIDTH + SCALE_WIDTH;
    localparam int CNT_W  = cnt_width(VEC_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    state_t                   state_r;
    state_t                   state_nxt_s;
    logic [CNT_W-1:0]         cnt_r;
    logic [CNT_W-1:0]         cnt_nxt_s;
    logic [SCALE_WIDTH-1:0]   scale_r;
    logic [SHIFT_WIDTH-1:0]   shift_r;

    logic                     en_s;
    logic                     cfg_fire_s;
    logic                     in_fire_s;
    logic                     last_s;
    logic signed [PROD_W-1:0] prod_s;

    logic                     s1_valid_r;
    s1_payload_t              s1_r;
    logic signed [OUT_WIDTH-1:0] s2_result_s;

    logic                     out_valid_r;
    logic [OUT_WIDTH-1:0]     out_data_r;
    logic                     out_last_r;

    assign en_s       = !out_valid_r || out_ready;
    assign cfg_ready  = (state_r == IDLE);
    assign in_ready   = (state_r == RUN) && en_s;
    assign cfg_fire_s = cfg_valid && cfg_ready;
    assign in_fire_s  = in_valid && in_ready;
    assign last_s     = (cnt_r == LAST_CNT);
    assign prod_s     = $signed(in_data) * $signed(scale_r);

    // Next-state and element-counter logic.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            IDLE: begin
                if (cfg_fire_s) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = cnt_r;
                end
            end
            RUN: begin
                if (in_fire_s && last_s) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (in_fire_s) begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = cnt_r + CNT_W'(1);
                end else begin
                    state_nxt_s = RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, counter and per-vector scale/shift registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            scale_r <= {SCALE_WIDTH{1'b0}};
            shift_r <= {SHIFT_WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            if (cfg_fire_s) begin
                scale_r <= cfg_scale;
                shift_r <= cfg_shift;
            end
        end
    end

    // S1: the product carries its own shift and last flag so a new cfg cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_r       <= {$bits(s1_payload_t){1'b0}};
        end else if (en_s) begin
            s1_valid_r <= in_fire_s;
            if (in_fire_s) begin
                s1_r.prod  <= prod_s;
                s1_r.shift <= shift_r;
                s1_r.last  <= last_s;
            end
        end
    end

    dequant_shift_round #(
        .PROD_WIDTH (PROD_W),
        .SHIFT_WIDTH(SHIFT_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
    ) u_shift_round (
        .prod  (s1_r.prod),
        .shift (s1_r.shift),
        .result(s2_result_s)
    );

    // S2: output register; data and last hold while the downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_WIDTH{1'b0}};
            out_last_r  <= 1'b0;
        end else if (en_s) begin
            out_valid_r <= s1_valid_r;
            out_last_r  <= s1_valid_r && s1_r.last;
            if (s1_valid_r) begin
                out_data_r <= s2_result_s;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;

endmodule

// File: tb/tb_dequant_stream.sv
// Self-checking bench for dequant_stream (VEC_LEN=4): directed table, corner sequences,
// and randomized traffic against a floor-division reference model with a scoreboard.
module tb_dequant_stream;

    localparam int VL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_scale;
    logic [3:0]  cfg_shift;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_data;
    logic        out_last;

    always #5 clk = ~clk;

    dequant_stream #(.VEC_LEN(VL)) dut (
        .clk(clk), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_scale(cfg_scale), .cfg_shift(cfg_shift),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    typedef struct {
        int scale;
        int shift;
        int x;
        int exp_floor;
        int exp_round;
    } vec_t;

    typedef struct {
        longint d;
        bit     last;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    longint m_scale = 0;
    longint m_shift = 0;
    int     m_cnt = 0;

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // x*scale / 2^shift, floored (or rounded half-up), done with integer division.
    function automatic longint ref_dq(input longint x, input longint s, input longint sh);
        longint p, d, q;
        p = x * s;
        d = 64'sd1 << sh;
`ifdef DEQUANT_ROUND_EN
        if (sh != 0) p = p + d / 2;
`endif
        q = p / d;
        if ((p % d != 0) && (p < 0)) q = q - 1;
        return q;
    endfunction

    task automatic mon_step();
        exp_t e;
        if (rst) begin
            sb_q.delete();
            m_cnt = 0; m_scale = 0; m_shift = 0;
        end else begin
            if (cfg_valid && cfg_ready) begin
                m_scale = $signed(cfg_scale);
                m_shift = cfg_shift;
                m_cnt   = 0;
            end
            if (in_valid && in_ready) begin
                e.d    = ref_dq($signed(in_data), m_scale, m_shift);
                e.last = (m_cnt == VL - 1);
                sb_q.push_back(e);
                m_cnt = (m_cnt + 1) % VL;
            end
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check(1'b0, "unexpected_output", $signed(out_data), 0);
                end else begin
                    e = sb_q.pop_front();
                    check($signed(out_data) == e.d, "out_data", $signed(out_data), e.d);
                    check(out_last == e.last, "out_last", out_last, e.last);
                end
            end
            if (out_valid && !out_ready) begin
                check(in_ready == 1'b0, "stall_in_ready", in_ready, 0);
            end
        end
    endtask

    task automatic send_cfg(input int s, input int sh);
        bit hs = 1'b0;
        int n = 0;
        cfg_valid = 1'b1;
        cfg_scale = s[11:0];
        cfg_shift = sh[3:0];
        while (!hs && n < 200) begin
            @(negedge clk); hs = cfg_ready;
            @(posedge clk); #1; n++;
        end
        cfg_valid = 1'b0;
        if (!hs) check(1'b0, "cfg_timeout", n, 200);
    endtask

    task automatic send_elem(input int d, input int gap);
        bit hs = 1'b0;
        int n = 0;
        repeat (gap) begin @(posedge clk); #1; end
        in_valid = 1'b1;
        in_data  = d[7:0];
        while (!hs && n < 200) begin
            @(negedge clk); hs = in_ready;
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        if (!hs) check(1'b0, "in_timeout", n, 200);
    endtask

    vec_t        tbl[8];
    logic [20:0] hold_d;
    logic        hold_l;
    bit          rand_ready;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int tmp;
        longint exp;
        tbl[0] = '{3,     0,  -128, -384,   -384};
        tbl[1] = '{-2048, 0,  -128, 262144, 262144};
        tbl[2] = '{5,     2,  7,    8,      9};
        tbl[3] = '{-5,    2,  7,    -9,     -9};
        tbl[4] = '{1,     1,  -1,   -1,     0};
        tbl[5] = '{2047,  15, 127,  7,      8};
        tbl[6] = '{100,   4,  -3,   -19,    -19};
        tbl[7] = '{0,     3,  55,   0,      0};

        rst = 1'b1; cfg_valid = 1'b0; cfg_scale = 12'd0; cfg_shift = 4'd0;
        in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1; rand_ready = 1'b0;

        fork
            forever begin @(negedge clk); mon_step(); end
        join_none

        repeat (3) @(posedge clk);
        #1;
        check(cfg_ready == 1'b1, "rst_cfg_ready", cfg_ready, 1);
        check(in_ready == 1'b0, "rst_in_ready", in_ready, 0);
        check(out_valid == 1'b0, "rst_out_valid", out_valid, 0);
        check(out_data == 21'd0, "rst_out_data", out_data, 0);
        check(out_last == 1'b0, "rst_out_last", out_last, 0);
        rst = 1'b0;

        // Directed table: first element of each vector checked for value and 2-cycle latency.
        for (int i = 0; i < 8; i++) begin
`ifdef DEQUANT_ROUND_EN
            exp = tbl[i].exp_round;
`else
            exp = tbl[i].exp_floor;
`endif
            send_cfg(tbl[i].scale, tbl[i].shift);
            tmp = tbl[i].x;
            in_valid = 1'b1; in_data = tmp[7:0];
            @(posedge clk); #1;
            check(out_valid == 1'b0, "lat_early", out_valid, 0);
            tmp = tbl[i].x + 1; in_data = tmp[7:0];
            @(posedge clk); #1;
            check(out_valid == 1'b1, "lat_valid", out_valid, 1);
            check($signed(out_data) == exp, "tbl_data", $signed(out_data), exp);
            tmp = tbl[i].x + 2; in_data = tmp[7:0];
            @(posedge clk); #1;
            tmp = tbl[i].x + 3; in_data = tmp[7:0];
            @(posedge clk); #1;
            in_valid = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
        end

        // Backpressure mid-stream: in_ready falls with out_ready, output holds 5 cycles.
        send_cfg(1, 0);
        fork
            for (int k = 1; k <= VL; k++) send_elem(k, 0);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                check(out_valid == 1'b1, "bp_out_valid", out_valid, 1);
                check(in_ready == 1'b0, "bp_in_ready_drop", in_ready, 0);
                hold_d = out_data; hold_l = out_last;
                repeat (5) begin
                    @(posedge clk); #1;
                    check(out_valid == 1'b1 && out_data == hold_d && out_last == hold_l,
                          "bp_hold", $signed(out_data), $signed(hold_d));
                end
                out_ready = 1'b1;
            end
        join
        repeat (4) begin @(posedge clk); #1; end

        // New cfg accepted one cycle after the last input while the old vector drains.
        send_cfg(1, 0);
        for (int k = 1; k <= VL; k++) send_elem(k, 0);
        check(cfg_ready == 1'b1, "cfg_gap_ready", cfg_ready, 1);
        send_cfg(2, 0);
        for (int k = 5; k <= 4 + VL; k++) send_elem(k, 0);
        repeat (4) begin @(posedge clk); #1; end

        // Mid-vector reset drops in-flight data and restarts cleanly.
        send_cfg(3, 1);
        send_elem(10, 0);
        send_elem(20, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check(out_valid == 1'b0, "mrst_out_valid", out_valid, 0);
        check(cfg_ready == 1'b1, "mrst_cfg_ready", cfg_ready, 1);
        check(in_ready == 1'b0, "mrst_in_ready", in_ready, 0);
        send_cfg(1, 0);
        for (int k = 0; k < VL; k++) send_elem(40 + k, 0);
        repeat (4) begin @(posedge clk); #1; end

        // Randomized traffic with random downstream stalls.
        rand_ready = 1'b1;
        fork
            begin
                for (int v = 0; v < 25; v++) begin
                    send_cfg(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 15)));
                    for (int k = 0; k < VL; k++)
                        send_elem(int'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
                end
                rand_ready = 1'b0;
            end
            begin
                while (rand_ready) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) begin @(posedge clk); #1; end
        check(sb_q.size() == 0, "drain_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dequant_stream.md
# dequant_stream

Streaming dequantizer: the inverse of the accumulator-to-int8 clip stage. It takes signed 8-bit activations on a valid/ready stream and rescales each one as x·scale, followed by an arithmetic right shift. The result is emitted sign-extended at accumulator width (21 bits) for the next wide-precision operator. Scale and shift are loaded once per vector of VEC_LEN elements through a config handshake, and the final output of each vector is flagged.

## Interface
- IN_WIDTH, 8: signed input element width.
- OUT_WIDTH, 21: signed output width; must be ≥ IN_WIDTH+SCALE_WIDTH+1.
- SCALE_WIDTH, 12: signed scale width.
- SHIFT_WIDTH, 4: unsigned right-shift amount width.
- VEC_LEN, 64: elements per vector, ≥1.
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  scale/shift offered.
- cfg_ready  out  1  high only in IDLE.
- cfg_scale  in  SCALE_WIDTH  signed scale.
- cfg_shift  in  SHIFT_WIDTH  right-shift amount.
- in_valid  in  1  input element valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_data  in  IN_WIDTH  signed element.
- out_valid  out  1  output element valid.
- out_ready  in  1  downstream accepts.
- out_data  out  OUT_WIDTH  signed dequantized element.
- out_last  out  1  marks the VEC_LEN-th output of a vector.

## Operation
- FSM states: IDLE and RUN.
  - IDLE: cfg_ready=1, in_ready=0. A cfg handshake latches scale and shift, clears the element counter, and moves to RUN.
  - RUN: cfg_ready=0. Each input handshake increments the counter. The handshake on count VEC_LEN-1 returns the FSM to IDLE and clears the counter.
- Pipeline, two stages with global enable en = !out_valid || out_ready.
  - S1 registers product p = in_data·scale. The product is IN_WIDTH+SCALE_WIDTH bits, signed.
  - S1 also registers the element's shift amount and last flag. Shift travels with the data.
  - S2 registers the shifted result, sign-extended to OUT_WIDTH. S2 drives out_*.
- in_ready = (state==RUN) && en.
- Stage valids advance only when en=1.
- A new cfg may be accepted while older elements are still in S1/S2. In-flight elements keep their own scale and shift.
- Arithmetic is exact; there is no overflow. |p| ≤ 2^18 at defaults, and the rounding add fits in OUT_WIDTH.
- Shift of 0 passes p unchanged.
- VEC_LEN=1: every input returns the FSM to IDLE, and every output has out_last=1.
- Reset mid-vector:
  - state=IDLE, counter=0, S1/S2 valid=0, scale=0, shift=0.
  - In-flight data is discarded and no partial out_last is emitted.
- Reset values: cfg_ready=1, in_ready=0, out_valid=0, out_data=0, out_last=0.

## Timing
- Latency from input handshake to out_valid is 2 cycles when out_ready is held high.
- Throughput is 1 element/cycle.
- out_valid=1 with out_ready=0: out_data and out_last hold, and in_ready drops in the same cycle (combinational from out_ready). No element is lost or duplicated.
- A cfg handshake in cycle t lets in_ready rise in cycle t+1 at the earliest. The minimum gap between vectors is 1 cycle.
- out_valid never depends combinationally on out_ready.

## Configuration
- DEQUANT_ROUND_EN defined: S2 computes (p + (shift≠0 ? 2^(shift-1) : 0)) >>> shift, i.e. round-half-up.
- DEQUANT_ROUND_EN undefined: S2 computes p >>> shift, i.e. floor (truncation toward −∞).
- Latency is unchanged either way.

## Structure
- dequant_pkg holds:
  - width localparams (product width, counter width = $clog2(VEC_LEN) with a floor of 1);
  - the FSM state enum {IDLE, RUN};
  - the S1 payload struct (product, shift, last).
- One sub-module, dequant_shift_round: combinational S2 datapath, under the DEQUANT_ROUND_EN switch.
- Top module holds the FSM, counter, pipeline registers and handshake logic.

## Test plan
- Basic scale, 2-cycle latency: cfg scale=3, shift=0; in_data=-128 (0x80) → out_data=-384 (0x1FFE80) 2 cycles later.
- Extreme product: scale=-2048, shift=0, in_data=-128 → out_data=262144 (0x040000), no overflow.
- Shift/round: scale=5, shift=2, in_data=7 → out 9 with DEQUANT_ROUND_EN, out 8 without.
- Backpressure: VEC_LEN=4, stream 1,2,3,4 with scale=1, out_ready low 5 cycles mid-stream → in_ready drops the same cycle. Outputs are 1,2,3,4 in order, out_last only on 4.
- Config during drain: new cfg (scale=2) accepted the cycle after the 4th input of a scale=1 vector → in-flight outputs still use scale 1; next vector uses scale 2.
- Mid-vector reset: rst after 2 of 4 inputs → next cycle out_valid=0, cfg_ready=1, in_ready=0. A following full vector ends with out_last on its 4th element.
